// File: rtl/key_scanner_pkg.sv
// Shared definitions for the key scanner and the game controller.
// Cell encoding, board size and the idle address value.
package key_scanner_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      X     = 2'b10,
      O     = 2'b11
   } cell_t;

   localparam int NUM_CELLS = 9;
   localparam logic [3:0] ADDR_IDLE = 4'b1111;

   // Lowest set bit wins; callers only use it on one-hot maps.
   function automatic logic [3:0] cell_index(
      input logic [NUM_CELLS-1:0] map
   );
      logic [3:0] idx;
      idx = '0;
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
         if (map[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/frame_debouncer.sv
// Assembles scanned columns into a full-matrix frame and
// promotes it to the debounced map after enough stable frames.
module frame_debouncer
   import key_scanner_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [NUM_CELLS-1:0] mask,
   input  logic [NUM_CELLS-1:0] sample,
   input  logic                 commit,
   output logic [NUM_CELLS-1:0] debounced
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES - 1);

   logic [NUM_CELLS-1:0] frame;
   logic [NUM_CELLS-1:0] prev;
   logic [NUM_CELLS-1:0] next_frame;
   logic [CW-1:0]        stable_cnt;
   logic [CW-1:0]        cnt_next;

   // The column being sampled replaces its three bits of the frame.
   always_comb begin
      next_frame = (frame & ~mask) | (sample & mask);
      cnt_next   = '0;
      if (next_frame == prev) begin
         cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt
                                            : stable_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame      <= '0;
         prev       <= '0;
         stable_cnt <= '0;
         debounced  <= '0;
      end else begin
         if (load) frame <= next_frame;
         if (commit) begin
            stable_cnt <= cnt_next;
            prev       <= next_frame;
            if (cnt_next == CNT_MAX) debounced <= next_frame;
         end
      end
   end

endmodule

// File: rtl/key_scanner.sv
// 3x3 key matrix scanner: synchronizes, scans and debounces the
// matrix, then validates presses against the board state.
module key_scanner
   import key_scanner_pkg::*;
#(
   parameter int SCAN_CYCLES     = 16,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic        ph1,
   input  logic        reset,
   input  logic [2:0]  keyRow,
   output logic [2:0]  keyCol,
   input  logic [17:0] gBoard,
   input  logic        gameIsDone,
   output logic [3:0]  playerInput,
   output logic        playerWrite,
   output logic        invalidPress
);

   localparam int CCW = $clog2(SCAN_CYCLES);
   localparam logic [CCW-1:0] CYC_LAST = CCW'(SCAN_CYCLES - 1);

   typedef enum logic {
      IDLE,
      WAIT_RELEASE
   } state_t;

   logic [2:0]           row_meta;
   logic [2:0]           row_sync;
   logic [2:0]           pressed;
   logic [CCW-1:0]       cycle_cnt;
   logic [1:0]           column;
   logic                 sample_edge;
   logic                 commit;
   logic [NUM_CELLS-1:0] mask;
   logic [NUM_CELLS-1:0] sample;
   logic [NUM_CELLS-1:0] debounced;

   state_t     state;
   state_t     state_next;
   logic [3:0] input_next;
   logic       write_next;
   logic       inv_next;
   logic       one_hot;
   logic [3:0] idx;
   logic       occupied;

   always_ff @(posedge ph1) begin
      if (reset) begin
         row_meta <= 3'b111;
         row_sync <= 3'b111;
      end else begin
         row_meta <= keyRow;
         row_sync <= row_meta;
      end
   end

   assign pressed = ~row_sync;

   always_ff @(posedge ph1) begin
      if (reset) begin
         cycle_cnt <= '0;
         column    <= '0;
      end else if (sample_edge) begin
         cycle_cnt <= '0;
         column    <= (column == 2'd2) ? 2'd0 : column + 2'd1;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   assign sample_edge = (cycle_cnt == CYC_LAST);
   assign commit      = sample_edge && (column == 2'd2);
   assign keyCol      = ~(3'b001 << column);

   // Bit row*3+col: each row's column-0 bit sits at 3*row.
   assign mask   = 9'b001_001_001 << column;
   assign sample = {2'b00, pressed[2], 2'b00, pressed[1],
                    2'b00, pressed[0]} << column;

   frame_debouncer #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_debouncer (
      .clk      (ph1),
      .reset    (reset),
      .load     (sample_edge),
      .mask     (mask),
      .sample   (sample),
      .commit   (commit),
      .debounced(debounced)
   );

   assign one_hot  = $onehot(debounced);
   assign idx      = cell_index(debounced);
   assign occupied = (gBoard[{idx, 1'b0} +: 2] != EMPTY);

   always_comb begin
      state_next = state;
      input_next = playerInput;
      write_next = 1'b0;
      inv_next   = 1'b0;
      unique case (state)
         IDLE: begin
            if (debounced != '0) begin
               state_next = WAIT_RELEASE;
               if (one_hot && !occupied && !gameIsDone) begin
                  write_next = 1'b1;
                  input_next = idx;
               end else begin
                  inv_next = 1'b1;
               end
            end
         end
         WAIT_RELEASE: begin
            if (debounced == '0) state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         state        <= IDLE;
         playerInput  <= ADDR_IDLE;
         playerWrite  <= 1'b0;
         invalidPress <= 1'b0;
      end else begin
         state        <= state_next;
         playerInput  <= input_next;
         playerWrite  <= write_next;
         invalidPress <= inv_next;
      end
   end

endmodule

// File: tb/tb_key_scanner.sv
// Directed bench for key_scanner: ideal key matrix model driven
// by keyCol, table of presses plus bounce and reset sequences.
module tb_key_scanner;
   import key_scanner_pkg::*;

   typedef struct {
      logic [8:0]  keys;
      logic [17:0] board;
      logic        done;
      int          exp_wr;
      int          exp_inv;
      logic [3:0]  exp_addr;
   } vec_t;

   logic        ph1 = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  keyRow;
   logic [2:0]  keyCol;
   logic [17:0] gBoard = '0;
   logic        gameIsDone = 1'b0;
   logic [3:0]  playerInput;
   logic        playerWrite;
   logic        invalidPress;
   logic [8:0]  keys = '0;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int inv_cnt = 0;
   int shape_bad = 0;
   logic pw_d = 1'b0;
   logic inv_d = 1'b0;

   vec_t vecs[8];

   always #5 ph1 = ~ph1;

   always_comb begin
      keyRow = 3'b111;
      for (int c = 0; c < 3; c++) begin
         if (keyCol[c] === 1'b0) begin
            for (int r = 0; r < 3; r++) begin
               if (keys[r*3+c]) keyRow[r] = 1'b0;
            end
         end
      end
   end

   key_scanner dut (
      .ph1         (ph1),
      .reset       (reset),
      .keyRow      (keyRow),
      .keyCol      (keyCol),
      .gBoard      (gBoard),
      .gameIsDone  (gameIsDone),
      .playerInput (playerInput),
      .playerWrite (playerWrite),
      .invalidPress(invalidPress)
   );

   // Strobe monitor: counts pulses, flags overlap or width > 1.
   always @(negedge ph1) begin
      if (playerWrite === 1'b1) wr_cnt++;
      if (invalidPress === 1'b1) inv_cnt++;
      if ((playerWrite === 1'b1 && invalidPress === 1'b1) ||
          (playerWrite === 1'b1 && pw_d === 1'b1) ||
          (invalidPress === 1'b1 && inv_d === 1'b1))
         shape_bad++;
      pw_d  = playerWrite;
      inv_d = invalidPress;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge ph1);
      @(negedge ph1);
      reset = 1'b0;
      check("rst_keyCol", keyCol, 3'b110);
      check("rst_playerInput", playerInput, ADDR_IDLE);
      check("rst_playerWrite", playerWrite, 1'b0);
      check("rst_invalidPress", invalidPress, 1'b0);
   endtask

   task automatic wait_strobe(input int limit, output int n);
      int w0;
      int i0;
      w0 = wr_cnt;
      i0 = inv_cnt;
      n = 0;
      while (wr_cnt == w0 && inv_cnt == i0 && n < limit) begin
         @(negedge ph1);
         n++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int w0;
      int i0;
      int n;
      w0 = wr_cnt;
      i0 = inv_cnt;
      gBoard = v.board;
      gameIsDone = v.done;
      keys = v.keys;
      wait_strobe(240, n);
      check($sformatf("v%0d_latency", k), n < 240, 1);
      repeat (96) @(negedge ph1);
      check($sformatf("v%0d_writes", k), wr_cnt - w0, v.exp_wr);
      check($sformatf("v%0d_invalid", k), inv_cnt - i0, v.exp_inv);
      check($sformatf("v%0d_addr", k), playerInput, v.exp_addr);
      check($sformatf("v%0d_shape", k), shape_bad, 0);
      keys = '0;
      w0 = wr_cnt;
      i0 = inv_cnt;
      repeat (288) @(negedge ph1);
      check($sformatf("v%0d_release_quiet", k),
            (wr_cnt - w0) + (inv_cnt - i0), 0);
   endtask

   initial begin
      int n;
      int w0;
      int i0;

      vecs[0] = '{9'h001, 18'h00002, 1'b0, 0, 1, 4'hF};
      vecs[1] = '{9'h011, 18'h00000, 1'b0, 0, 1, 4'hF};
      vecs[2] = '{9'h080, 18'h00000, 1'b1, 0, 1, 4'hF};
      vecs[3] = '{9'h020, 18'h00000, 1'b0, 1, 0, 4'h5};
      vecs[4] = '{9'h020, 18'h00000, 1'b0, 1, 0, 4'h5};
      vecs[5] = '{9'h100, 18'h0FFFF, 1'b0, 1, 0, 4'h8};
      vecs[6] = '{9'h008, 18'h000C0, 1'b0, 0, 1, 4'h8};
      vecs[7] = '{9'h002, 18'h00022, 1'b0, 1, 0, 4'h1};

      do_reset();
      repeat (16) @(negedge ph1);
      check("scan_col1", keyCol, 3'b101);
      repeat (16) @(negedge ph1);
      check("scan_col2", keyCol, 3'b011);
      repeat (16) @(negedge ph1);
      check("scan_wrap", keyCol, 3'b110);

      for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

      // Bounce on cell 0, then hold it.
      gBoard = '0;
      gameIsDone = 1'b0;
      w0 = wr_cnt;
      i0 = inv_cnt;
      for (int i = 0; i < 15; i++) begin
         keys[0] = ~keys[0];
         repeat (20) @(negedge ph1);
      end
      check("bounce_quiet", (wr_cnt - w0) + (inv_cnt - i0), 0);
      check("bounce_key_held", keys, 9'h001);
      w0 = wr_cnt;
      wait_strobe(240, n);
      repeat (96) @(negedge ph1);
      check("bounce_writes", wr_cnt - w0, 1);
      check("bounce_addr", playerInput, 4'h0);
      keys = '0;
      repeat (288) @(negedge ph1);

      // Reset two frames into a cell-3 press.
      keys = 9'h008;
      repeat (96) @(negedge ph1);
      w0 = wr_cnt;
      i0 = inv_cnt;
      do_reset();
      check("midrst_quiet", (wr_cnt - w0) + (inv_cnt - i0), 0);
      wait_strobe(240, n);
      check("midrst_latency_max", n < 240, 1);
      check("midrst_latency_min", n >= 140, 1);
      repeat (96) @(negedge ph1);
      check("midrst_writes", wr_cnt - w0, 1);
      check("midrst_invalid", inv_cnt - i0, 0);
      check("midrst_addr", playerInput, 4'h3);
      check("final_shape", shape_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
